// File: rtl/clk_gate_pkg.sv
// ----------------------------------------------------------------------------
// clk_gate_pkg
//
// Purpose: shared definitions for the clock-gate controller and the system
// top that instantiates it.
//   - cg_state_e : FSM state encoding (OFF/WAKE/ON/IDLE)
//   - DEF_*      : default hysteresis / wake timing, reused by the system top
// No ports (package).
// ----------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_WAKE = 2'b01,
        ST_ON   = 2'b10,
        ST_IDLE = 2'b11
    } cg_state_e;

    localparam int DEF_IDLE_CYCLES = 8;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_CNT_W       = 4;

    // Largest timing constant the shared counter has to reach.
    function automatic int cg_max_cycles(input int idle_cycles, input int wake_cycles);
        return (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Purpose: produces the registered enable for the clock-gating cell of one
// gated domain. Wakes the domain on REQ (or BUSY), waits WAKE_CYCLES before
// reporting READY, holds the clock while the consumer is active, and gates
// off only after IDLE_CYCLES consecutive idle cycles.
//
// Ports:
//   CLK       in   free-running (ungated) clock
//   RST       in   asynchronous, active-high reset
//   REQ       in   activity request, level, held while work is pending
//   BUSY      in   consumer still operating (already resynchronised)
//   TEST_EN   in   scan/test override (only when CLK_GATE_TEST_EN is defined)
//   GATE_EN   out  registered enable to the clock-gating cell
//   READY     out  gated clock stable, requester may issue work
//   SLEEP     out  domain gated off (state OFF)
//   dbg_state out  current FSM state, for observation only
//
// Optional feature macro: CLK_GATE_TEST_EN
//   When defined, TEST_EN=1 forces GATE_EN and READY high after the output
//   registers; the FSM keeps running underneath.
//
// Handshake: REQ/BUSY are level signals, not valid/ready pulses. The
// requester raises REQ and may issue work only while READY=1; READY stays
// high for as long as REQ or BUSY stays high.
// ----------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      REQ,
    input  logic      BUSY,
`ifdef CLK_GATE_TEST_EN
    input  logic      TEST_EN,
`endif
    output logic      GATE_EN,
    output logic      READY,
    output logic      SLEEP,
    output cg_state_e dbg_state
);

    // Terminal counter values. WAKE_LAST is never used when WAKE_CYCLES=0
    // because OFF then skips the WAKE state entirely.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST =
        CNT_W'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    cg_state_e        state;
    cg_state_e        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             act;

    logic             gate_en_q;
    logic             ready_q;
    logic             sleep_q;

    // BUSY also counts as activity so a consumer still running while OFF
    // (e.g. a missed REQ) gets its clock back.
    assign act = REQ | BUSY;

    // ------------------------------------------------------------------------
    // Next-state / next-counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        next_cnt   = cnt;

        unique case (state)
            ST_OFF: begin
                if (act) begin
                    next_state = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
                    next_cnt   = '0;
                end
            end

            // Inputs are deliberately ignored here: once the clock starts it
            // always settles to ON before it can be gated again.
            ST_WAKE: begin
                if (cnt == WAKE_LAST) begin
                    next_state = ST_ON;
                    next_cnt   = '0;
                end else if (cnt != CNT_MAX) begin
                    next_cnt = cnt + 1'b1;
                end
            end

            ST_ON: begin
                if (!act) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end
            end

            // act has priority over the terminal count, so the clock is
            // never removed on a cycle where activity is sampled.
            ST_IDLE: begin
                if (act) begin
                    next_state = ST_ON;
                    next_cnt   = '0;
                end else if (cnt == IDLE_LAST) begin
                    next_state = ST_OFF;
                    next_cnt   = '0;
                end else if (cnt != CNT_MAX) begin
                    next_cnt = cnt + 1'b1;
                end
            end

            default: begin
                next_state = ST_OFF;
                next_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------------
    // Outputs are registered from the decoded next state so they are clean
    // flop outputs (no decode glitches from multi-bit state changes) while
    // still matching the state register cycle for cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_OFF;
            cnt       <= '0;
            gate_en_q <= 1'b0;
            ready_q   <= 1'b0;
            sleep_q   <= 1'b1;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            gate_en_q <= (next_state != ST_OFF);
            ready_q   <= (next_state == ST_ON) || (next_state == ST_IDLE);
            sleep_q   <= (next_state == ST_OFF);
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
`ifdef CLK_GATE_TEST_EN
    // Test override is ORed after the flops so scan can run the domain
    // regardless of the FSM; SLEEP keeps reporting the FSM view.
    assign GATE_EN = gate_en_q | TEST_EN;
    assign READY   = ready_q   | TEST_EN;
`else
    assign GATE_EN = gate_en_q;
    assign READY   = ready_q;
`endif
    assign SLEEP     = sleep_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Directed bench for clk_gate_ctrl. dut_a uses the default timing
// (IDLE_CYCLES=8, WAKE_CYCLES=2); dut_b uses WAKE_CYCLES=0, IDLE_CYCLES=1.
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, away from the active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_gate_ctrl;
    import clk_gate_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic      req_a, busy_a, gate_a, ready_a, sleep_a;
    logic      req_b, busy_b, gate_b, ready_b, sleep_b;
    cg_state_e st_a, st_b;
`ifdef CLK_GATE_TEST_EN
    logic      test_en;
`endif

    clk_gate_ctrl #(
        .IDLE_CYCLES (8),
        .WAKE_CYCLES (2),
        .CNT_W       (4)
    ) dut_a (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req_a),
        .BUSY      (busy_a),
`ifdef CLK_GATE_TEST_EN
        .TEST_EN   (test_en),
`endif
        .GATE_EN   (gate_a),
        .READY     (ready_a),
        .SLEEP     (sleep_a),
        .dbg_state (st_a)
    );

    clk_gate_ctrl #(
        .IDLE_CYCLES (1),
        .WAKE_CYCLES (0),
        .CNT_W       (2)
    ) dut_b (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req_b),
        .BUSY      (busy_b),
`ifdef CLK_GATE_TEST_EN
        .TEST_EN   (1'b0),
`endif
        .GATE_EN   (gate_b),
        .READY     (ready_b),
        .SLEEP     (sleep_b),
        .dbg_state (st_b)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs of dut_a packed as {state[1:0], gate, ready} plus sleep.
    task automatic check_a(input string tag, input cg_state_e st,
                           input logic g, input logic r, input logic s);
        check({tag, ".state"}, {2'b00, st_a},    {2'b00, st});
        check({tag, ".gate"},  {3'b000, gate_a}, {3'b000, g});
        check({tag, ".ready"}, {3'b000, ready_a}, {3'b000, r});
        check({tag, ".sleep"}, {3'b000, sleep_a}, {3'b000, s});
    endtask

    task automatic check_b(input string tag, input cg_state_e st,
                           input logic g, input logic r, input logic s);
        check({tag, ".state"}, {2'b00, st_b},    {2'b00, st});
        check({tag, ".gate"},  {3'b000, gate_b}, {3'b000, g});
        check({tag, ".ready"}, {3'b000, ready_b}, {3'b000, r});
        check({tag, ".sleep"}, {3'b000, sleep_b}, {3'b000, s});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst    = 1'b1;
        req_a  = 1'b1;
        busy_a = 1'b0;
        req_b  = 1'b0;
        busy_b = 1'b0;
`ifdef CLK_GATE_TEST_EN
        test_en = 1'b0;
`endif

        // Reset held with REQ high: domain must stay gated.
        ticks(3);
        check_a("rst_hold", ST_OFF, 1'b0, 1'b0, 1'b1);
        check_b("rst_hold_b", ST_OFF, 1'b0, 1'b0, 1'b1);

        // Release; REQ already high so first edge moves to WAKE.
        rst = 1'b0;
        tick();
        check_a("wake_e0", ST_WAKE, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("wake_e1", ST_WAKE, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("on_e2", ST_ON, 1'b1, 1'b1, 1'b0);
        ticks(3);
        check_a("on_hold", ST_ON, 1'b1, 1'b1, 1'b0);

        // Full idle hysteresis: one edge to IDLE, then 8 more to OFF.
        req_a = 1'b0;
        tick();
        check_a("idle_enter", ST_IDLE, 1'b1, 1'b1, 1'b0);
        ticks(7);
        check_a("idle_last", ST_IDLE, 1'b1, 1'b1, 1'b0);
        tick();
        check_a("idle_off", ST_OFF, 1'b0, 1'b0, 1'b1);

        // REQ pulse dropped during WAKE: wake completes, then idles.
        req_a = 1'b1;
        tick();
        check_a("w2_wake", ST_WAKE, 1'b1, 1'b0, 1'b0);
        req_a = 1'b0;
        ticks(2);
        check_a("w2_on", ST_ON, 1'b1, 1'b1, 1'b0);
        tick();
        check_a("w2_idle", ST_IDLE, 1'b1, 1'b1, 1'b0);

        // BUSY on the terminal IDLE cycle wins over gating off.
        ticks(7);
        check_a("term_pre", ST_IDLE, 1'b1, 1'b1, 1'b0);
        busy_a = 1'b1;
        tick();
        check_a("term_react", ST_ON, 1'b1, 1'b1, 1'b0);

        // Mid-IDLE reactivation must restart the hysteresis count.
        busy_a = 1'b0;
        tick();
        ticks(3);
        check_a("mid_idle", ST_IDLE, 1'b1, 1'b1, 1'b0);
        req_a = 1'b1;
        tick();
        check_a("mid_react", ST_ON, 1'b1, 1'b1, 1'b0);
        req_a = 1'b0;
        tick();
        ticks(7);
        check_a("restart_last", ST_IDLE, 1'b1, 1'b1, 1'b0);
        tick();
        check_a("restart_off", ST_OFF, 1'b0, 1'b0, 1'b1);

        // dut_b: WAKE_CYCLES=0, BUSY-only wake goes straight to ON.
        busy_b = 1'b1;
        tick();
        check_b("b_busy_on", ST_ON, 1'b1, 1'b1, 1'b0);
        busy_b = 1'b0;
        tick();
        check_b("b_idle", ST_IDLE, 1'b1, 1'b1, 1'b0);
        tick();
        check_b("b_off", ST_OFF, 1'b0, 1'b0, 1'b1);

        // Async reset pulse mid-ON: outputs drop without a clock edge.
        req_b = 1'b1;
        tick();
        check_b("b_req_on", ST_ON, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_b("b_async_rst", ST_OFF, 1'b0, 1'b0, 1'b1);
        tick();
        req_b = 1'b0;
        rst   = 1'b0;
        tick();
        check_b("b_after_rst", ST_OFF, 1'b0, 1'b0, 1'b1);

`ifdef CLK_GATE_TEST_EN
        // Test override forces enable/ready immediately, FSM stays OFF.
        test_en = 1'b1;
        #1;
        check_a("test_force", ST_OFF, 1'b1, 1'b1, 1'b1);
        tick();
        check_a("test_hold", ST_OFF, 1'b1, 1'b1, 1'b1);
        test_en = 1'b0;
        #1;
        check_a("test_release", ST_OFF, 1'b0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Generates the registered gate-enable consumed by the clock-gating cell (Gate_EN input) for one gated domain, e.g. the ALU clock. Wakes the domain on request. Holds it awake while the consumer is busy. Gates it off only after a programmable idle hysteresis. Tells the requester when the gated clock is usable.

Parameters:
IDLE_CYCLES, 8, consecutive idle cycles in IDLE before gating off (must be >= 1)
WAKE_CYCLES, 2, cycles between GATE_EN rising and READY rising (0 allowed)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(IDLE_CYCLES, WAKE_CYCLES)

Ports:
CLK  input  1  free-running (ungated) domain clock
RST  input  1  asynchronous, active-high reset
REQ  input  1  activity request from system controller, level, held while work is pending
BUSY  input  1  consumer still operating (from the gated domain, resynchronised by caller)
GATE_EN  output  1  registered enable to the clock-gating cell
READY  output  1  gated clock stable; requester may issue work
SLEEP  output  1  high when the domain is gated off (state OFF)

Behaviour:
- Single clock (CLK), asynchronous active-high reset (RST).
- All outputs are registered, decoded from the state register. No combinational path from inputs to outputs.
- Reset values: state OFF, GATE_EN=0, READY=0, SLEEP=1, counter=0.
- States: OFF, WAKE, ON, IDLE. GATE_EN=1 in WAKE/ON/IDLE; READY=1 in ON/IDLE; SLEEP=1 in OFF only.
- act = REQ | BUSY. BUSY while OFF is treated as a wake source, so a missed REQ cannot leave the consumer unclocked.
- OFF:
  - act=1 at edge n -> WAKE at n+1 (GATE_EN=1 from n+1), counter cleared.
  - If WAKE_CYCLES=0, go straight to ON.
- WAKE:
  - Counter increments each cycle.
  - When counter == WAKE_CYCLES-1 -> ON, counter cleared.
  - READY therefore rises exactly WAKE_CYCLES cycles after GATE_EN.
  - Inputs are ignored in WAKE. A dropped REQ does not abort the wake; the FSM completes to ON, then to IDLE.
- ON:
  - act=0 -> IDLE, counter cleared.
  - Otherwise stay.
- IDLE:
  - act=1 -> ON, counter cleared.
  - Else if counter == IDLE_CYCLES-1 -> OFF (GATE_EN, READY fall together, SLEEP rises).
  - Else counter increments.
  - Total gate-off latency: IDLE_CYCLES+1 edges after act falls in ON.
- Simultaneous: act=1 on the terminal IDLE cycle wins -> ON. The domain is never gated on a cycle where act is sampled high.
- Counter saturates and never wraps; wrap is unreachable given the CNT_W rule.
- RST mid-operation: immediate return to OFF, GATE_EN=0 asynchronously. The gating cell's own latch blocks the glitch while CLK is high.
- Glitch rule: GATE_EN changes only on CLK rising edge.

Optional Feature:
Macro CLK_GATE_TEST_EN.
- Defined:
  - Adds input TEST_EN (1 bit).
  - When TEST_EN=1, GATE_EN is forced 1 (ORed after the register, for scan) and READY is forced 1.
  - The FSM keeps running normally, so releasing TEST_EN returns to FSM-controlled outputs on the next cycle.
- Undefined: no TEST_EN port; outputs purely from the FSM.

Decomposition:
- Shared package clk_gate_pkg:
  - state encoding constants (OFF=2'b00, WAKE=2'b01, ON=2'b10, IDLE=2'b11)
  - default IDLE_CYCLES/WAKE_CYCLES values, reused by the system top
- No sub-module needed. The single shared counter plus FSM stay in one module.
- The top level instantiates clk_gate_ctrl directly feeding the clock-gating cell.

Test Plan:
- Reset: RST=1 with REQ=1 -> GATE_EN=0, READY=0, SLEEP=1 held. Release -> GATE_EN=1 one edge after first sampled REQ.
- Wake latency, defaults: REQ rises before edge 10 -> GATE_EN=1 after edge 10, READY=1 after edge 12, SLEEP=0 after edge 10.
- Idle hysteresis, IDLE_CYCLES=8: drop REQ/BUSY in ON at edge 20 -> IDLE at 21, OFF after edge 29, GATE_EN=0.
- Reactivation on terminal idle cycle: BUSY=1 sampled on edge 29 -> state ON, GATE_EN stays 1, READY stays 1, no gap.
- WAKE_CYCLES=0 build plus BUSY-only wake: BUSY=1 in OFF -> GATE_EN and READY both 1 one edge later. RST pulse mid-ON -> immediate OFF.
- CLK_GATE_TEST_EN build: TEST_EN=1 in OFF -> GATE_EN=1, READY=1 same cycle. Drop TEST_EN -> back to 0 with SLEEP=1.
